// File: rtl/hc_pkg.sv
`default_nettype none
// =============================================================================
// hc_pkg : constants, state type and decode helper shared by the HC148 blocks
// Rev 1.0
// =============================================================================
package hc_pkg;

    localparam int          CODE_W   = 3;
    localparam int          ONEHOT_W = 8;
    localparam int          VEC_W    = CODE_W + 2;
    localparam logic [4:0]  IDLE_VEC = 5'b11111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HELD = 2'd2
    } hc_state_t;

    // Active-low one-hot in 74HC138 form for a positive-logic code.
    function automatic logic [ONEHOT_W-1:0] hc_onehot_n(input logic [CODE_W-1:0] code);
        return ~(ONEHOT_W'(1) << code);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hc_sync_debounce.sv
`default_nettype none
// =============================================================================
// hc_sync_debounce : two-flop synchroniser followed by a stability counter
// Rev 1.0
// =============================================================================
module hc_sync_debounce #(
    parameter int               WIDTH      = 5,
    parameter int               STABLE_CYC = 4,
    parameter int               CNT_W      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(STABLE_CYC - 1);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_change;

    // r_sync is the previous-cycle value of r_meta, so a change is seen one
    // cycle earlier than comparing r_sync with a third register would.
    assign w_change = (r_meta != r_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= RESET_VAL;
            r_sync   <= RESET_VAL;
            r_stable <= RESET_VAL;
            r_cnt    <= c_cnt_max;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            if (w_change) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (!w_change && (r_cnt == c_cnt_load)) begin
                r_stable <= r_sync;
            end
        end
    end

    assign q = r_stable;

endmodule
`default_nettype wire

// File: rtl/hc148_rx_decoder.sv
`default_nettype none
// =============================================================================
// hc148_rx_decoder : debounced HC148 code re-expanded to HC138 form, with a
//                    one-shot valid/ack event per new stable code
// Rev 1.0
// =============================================================================
module hc148_rx_decoder
    import hc_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CODE_W-1:0]   a_n,
    input  logic                gs_n,
    input  logic                eo_n,
    input  logic                en,
    output logic [ONEHOT_W-1:0] y_n,
    output logic [CODE_W-1:0]   code,
    output logic                valid,
    input  logic                ack,
    output logic                overrun,
    output logic                idle_o
);

    logic [VEC_W-1:0]    w_stable;
    logic [VEC_W-1:0]    r_prev_stable;
    logic [CODE_W-1:0]   w_st_a_n;
    logic                w_st_gs_n;
    logic                w_st_eo_n;
    logic                w_event;

    hc_state_t           r_state;
    hc_state_t           w_state_nxt;
    logic                w_capture;
    logic                w_set_ovr;
    logic                w_clr_ovr;

    logic [ONEHOT_W-1:0] r_y_n;
    logic [CODE_W-1:0]   r_code;
    logic                r_overrun;
    logic                r_idle;

    hc_sync_debounce #(
        .WIDTH      (VEC_W),
        .STABLE_CYC (STABLE_CYC),
        .CNT_W      (CNT_W),
        .RESET_VAL  (IDLE_VEC)
    ) u_sync_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({a_n, gs_n, eo_n}),
        .q     (w_stable)
    );

    assign w_st_a_n  = w_stable[4:2];
    assign w_st_gs_n = w_stable[1];
    assign w_st_eo_n = w_stable[0];

    // A new event is a stable falling gs_n or a stable code change while active.
    assign w_event = !w_st_gs_n &&
                     (r_prev_stable[1] || (r_prev_stable[4:2] != w_st_a_n));

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_set_ovr   = 1'b0;
        w_clr_ovr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_event) begin
                    w_capture   = 1'b1;
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (ack) begin
                    w_clr_ovr = 1'b1;
                    if (w_event) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_nxt = w_st_gs_n ? IDLE : HELD;
                    end
                end else if (w_event) begin
                    w_set_ovr = 1'b1;
                end
            end
            HELD: begin
                if (w_event) begin
                    w_capture   = 1'b1;
                    w_state_nxt = PEND;
                end else if (w_st_gs_n) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_prev_stable <= IDLE_VEC;
            r_code        <= '0;
            r_overrun     <= 1'b0;
            r_y_n         <= '1;
            r_idle        <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_stable <= w_stable;
            r_idle        <= w_st_eo_n;
            r_y_n         <= (en && !w_st_gs_n) ? hc_onehot_n(~w_st_a_n) : '1;
            if (w_capture) begin
                r_code <= ~w_st_a_n;
            end
            if (w_clr_ovr) begin
                r_overrun <= 1'b0;
            end else if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign y_n     = r_y_n;
    assign code    = r_code;
    assign valid   = (r_state == PEND);
    assign overrun = r_overrun;
    assign idle_o  = r_idle;

endmodule
`default_nettype wire
